// File: rtl/div_ctrl_pkg.sv
// Shared CPU definitions used by the divide controller: ALU control codes
// for the two divide flavours, the controller state type and a decode helper.
package div_ctrl_pkg;

    localparam int OP_W   = 6;
    localparam int DATA_W = 32;

    // ALU control codes that route an EX instruction to the iterative divider.
    localparam logic [OP_W-1:0] DIV_CONTROL  = 6'b011010;
    localparam logic [OP_W-1:0] DIVU_CONTROL = 6'b011011;

    // Divide controller states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DONE  = 2'd2,
        ST_ABORT = 2'd3
    } div_state_e;

    // True when the ALU control code selects either divide.
    function automatic logic is_div_op(input logic [OP_W-1:0] op);
        return (op == DIV_CONTROL) || (op == DIVU_CONTROL);
    endfunction

endpackage

// File: rtl/div_ctrl.sv
// Divide controller: sits between the EX stage and the 32-clock divider.
// It launches a divide, stalls EX while the divider works, hands the
// remainder/quotient back on hi_o/lo_o, and annuls the divider on a flush.
// Divide-by-zero never reaches the divider; it completes at once with zeros.
module div_ctrl
    import div_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,

    // EX stage
    input  logic [OP_W-1:0]     ex_op_i,
    input  logic [DATA_W-1:0]   ex_opdata1_i,
    input  logic [DATA_W-1:0]   ex_opdata2_i,
    input  logic                flush_i,
    input  logic                ex_hold_i,

    // Divider request side
    output logic [OP_W-1:0]     div_op_o,
    output logic [DATA_W-1:0]   div_opdata1_o,
    output logic [DATA_W-1:0]   div_opdata2_o,
    output logic                div_start_o,
    output logic                div_annul_o,

    // Divider response side
    input  logic [2*DATA_W-1:0] div_result_i,
    input  logic                div_ready_i,

    // Back to EX
    output logic                stall_req_o,
    output logic                result_valid_o,
    output logic [DATA_W-1:0]   hi_o,
    output logic [DATA_W-1:0]   lo_o
);

    div_state_e          state_reg;
    div_state_e          state_next;

    logic [OP_W-1:0]     div_op_reg;
    logic [OP_W-1:0]     div_op_next;
    logic [DATA_W-1:0]   opdata1_reg;
    logic [DATA_W-1:0]   opdata1_next;
    logic [DATA_W-1:0]   opdata2_reg;
    logic [DATA_W-1:0]   opdata2_next;
    logic                start_reg;
    logic                start_next;
    logic                annul_reg;
    logic                annul_next;
    logic [DATA_W-1:0]   hi_reg;
    logic [DATA_W-1:0]   hi_next;
    logic [DATA_W-1:0]   lo_reg;
    logic [DATA_W-1:0]   lo_next;
    logic                valid_reg;
    logic                valid_next;

    logic                is_div;
    logic                issue_req;
    logic                divisor_zero;

    // Decode of the instruction currently in EX. A flushed instruction is
    // dead, so it neither issues nor stalls.
    assign is_div       = is_div_op(ex_op_i);
    assign issue_req    = is_div && !flush_i;
    assign divisor_zero = (ex_opdata2_i == '0);

    // State and registered outputs; everything clears on reset, which also
    // silently abandons an in-flight divide (the divider shares the reset).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            div_op_reg  <= '0;
            opdata1_reg <= '0;
            opdata2_reg <= '0;
            start_reg   <= 1'b0;
            annul_reg   <= 1'b0;
            hi_reg      <= '0;
            lo_reg      <= '0;
            valid_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            div_op_reg  <= div_op_next;
            opdata1_reg <= opdata1_next;
            opdata2_reg <= opdata2_next;
            start_reg   <= start_next;
            annul_reg   <= annul_next;
            hi_reg      <= hi_next;
            lo_reg      <= lo_next;
            valid_reg   <= valid_next;
        end
    end

    // Next-state and next-output logic; every register holds by default.
    always_comb begin
        state_next   = state_reg;
        div_op_next  = div_op_reg;
        opdata1_next = opdata1_reg;
        opdata2_next = opdata2_reg;
        start_next   = start_reg;
        annul_next   = annul_reg;
        hi_next      = hi_reg;
        lo_next      = lo_reg;
        valid_next   = valid_reg;

        unique case (state_reg)
            ST_IDLE: begin
                // The only state that accepts work, which guarantees a
                // low cycle on div_start_o between back-to-back divides.
                start_next = 1'b0;
                annul_next = 1'b0;
                valid_next = 1'b0;
                if (issue_req) begin
                    if (!divisor_zero) begin
                        // Op passes through untouched; the divider owns
                        // the signed/unsigned distinction.
                        div_op_next  = ex_op_i;
                        opdata1_next = ex_opdata1_i;
                        opdata2_next = ex_opdata2_i;
                        start_next   = 1'b1;
                        state_next   = ST_BUSY;
                    end else begin
                        // Divide by zero: defined result of zero, no divider.
                        hi_next    = '0;
                        lo_next    = '0;
                        valid_next = 1'b1;
                        state_next = ST_DONE;
                    end
                end
            end

            ST_BUSY: begin
                // Operands and start stay frozen until the divider answers;
                // no latency is assumed. Flush beats a same-cycle ready.
                if (flush_i) begin
                    start_next = 1'b0;
                    annul_next = 1'b1;
                    state_next = ST_ABORT;
                end else if (div_ready_i) begin
                    hi_next    = div_result_i[2*DATA_W-1:DATA_W];
                    lo_next    = div_result_i[DATA_W-1:0];
                    start_next = 1'b0;
                    valid_next = 1'b1;
                    state_next = ST_DONE;
                end
            end

            ST_DONE: begin
                // Result is presented until EX moves on or is flushed.
                if (!ex_hold_i || flush_i) begin
                    valid_next = 1'b0;
                    state_next = ST_IDLE;
                end
            end

            ST_ABORT: begin
                // Single-cycle annul pulse; never issues from here.
                annul_next = 1'b0;
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // EX stall: a live divide waiting to issue, or one in the divider.
    assign stall_req_o = ((state_reg == ST_IDLE) && issue_req) ||
                         (state_reg == ST_BUSY);

    assign div_op_o       = div_op_reg;
    assign div_opdata1_o  = opdata1_reg;
    assign div_opdata2_o  = opdata2_reg;
    assign div_start_o    = start_reg;
    assign div_annul_o    = annul_reg;
    assign hi_o           = hi_reg;
    assign lo_o           = lo_reg;
    assign result_valid_o = valid_reg;

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 clk  in  1  single clock; all state updates on the rising edge.
REQ-002 rst_n  in  1  asynchronous active-low reset.
REQ-003 ex_op_i  in  6  ALU control code of the instruction in EX; `DIV_CONTROL or `DIVU_CONTROL selects a divide.
REQ-004 ex_opdata1_i / ex_opdata2_i  in  32 each  dividend / divisor from EX.
REQ-005 flush_i  in  1  pipeline flush; kills the instruction in EX.
REQ-006 ex_hold_i  in  1  EX stage held by a downstream stall; the divide instruction stays in EX.
REQ-007 div_op_o  out  6  op to the 32-clock divider, registered.
REQ-008 div_opdata1_o / div_opdata2_o  out  32 each  divider operands, registered.
REQ-009 div_start_o / div_annul_o  out  1 each  divider start / annul, registered.
REQ-010 div_result_i  in  64  divider result: [63:32] remainder, [31:0] quotient.
REQ-011 div_ready_i  in  1  divider result valid.
REQ-012 stall_req_o  out  1  EX stall request, combinational.
REQ-013 result_valid_o  out  1  hi_o / lo_o valid for EX.
REQ-014 hi_o / lo_o  out  32 each  remainder / quotient, registered.

Function
REQ-015 States SHALL be IDLE, BUSY, DONE, ABORT.
REQ-016 is_div = (ex_op_i == `DIV_CONTROL or `DIVU_CONTROL).
REQ-017 IDLE, is_div, !flush_i, ex_opdata2_i != 0: latch op and operands onto div_* outputs, set div_start_o=1, go to BUSY.
REQ-018 IDLE, is_div, !flush_i, ex_opdata2_i == 0: skip the divider, set hi_o=0 and lo_o=0, go to DONE; div_start_o stays 0.
REQ-019 stall_req_o = (IDLE & is_div & !flush_i) | BUSY.
REQ-020 BUSY: div_start_o and the div_* operands SHALL stay constant; div_ready_i SHALL be waited for without a fixed latency assumption.
REQ-021 BUSY with div_ready_i=1 and !flush_i: capture hi_o=div_result_i[63:32] and lo_o=div_result_i[31:0], clear div_start_o, go to DONE.
REQ-022 BUSY with flush_i=1: go to ABORT with div_start_o=0 and div_annul_o=1. Flush SHALL win over a simultaneous div_ready_i, and no result is captured.
REQ-023 ABORT lasts exactly one cycle with div_annul_o=1, stall_req_o=0, result_valid_o=0, then IDLE clears div_annul_o. No issue SHALL occur from ABORT.
REQ-024 DONE: result_valid_o=1, stall_req_o=0, div_start_o=0, so the divider returns to free.
REQ-025 DONE exits to IDLE when ex_hold_i=0 or flush_i=1; otherwise hold_o, lo_o and result_valid_o SHALL be held.
REQ-026 A new divide SHALL be accepted only from IDLE, so div_start_o is low for at least one cycle between operations.
REQ-027 Signed/unsigned handling SHALL remain in the divider; this controller passes the op through unchanged.
REQ-028 flush_i in IDLE SHALL suppress issue and stall.

Reset
REQ-029 On rst_n=0, asynchronously: state=IDLE; div_start_o=0, div_annul_o=0, div_op_o=0, div_opdata1_o=0, div_opdata2_o=0, hi_o=0, lo_o=0, result_valid_o=0.
REQ-030 Reset mid-BUSY SHALL abandon the operation, with no annul pulse; the divider is reset by the same reset tree.

Structure
REQ-031 The state enum, and the `DIV_CONTROL / `DIVU_CONTROL codes from alu_defines, SHALL live in the shared CPU package/defines; no local copies.
REQ-032 div_ctrl SHALL be a single module with no sub-modules; the top level instantiates it beside divider_32clock.

Verification
REQ-033 DIV 0xFFFFFFF9 / 0x00000002, ex_hold_i=0: stall_req_o high from the issue cycle until ready; then hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFD, result_valid_o=1 for 1 cycle.
REQ-034 DIVU 0xFFFFFFF9 / 0x00000002: hi_o=0x00000001, lo_o=0x7FFFFFFC.
REQ-035 DIV x / 0: next cycle DONE with hi_o=0, lo_o=0, div_start_o never asserted, stall_req_o high for 1 cycle only.
REQ-036 flush_i at BUSY cycle 10: div_annul_o pulses 1 cycle, no result_valid_o; an immediate following DIVU 100/7 returns hi=2, lo=14.
REQ-037 Result in DONE with ex_hold_i=1 for 5 cycles: hi_o/lo_o/result_valid_o stable 5 cycles, IDLE after release.
REQ-038 rst_n low mid-BUSY: all outputs 0 asynchronously; a divide issued after reset completes correctly.
